// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter shared definitions.
// State encoding and default abort read data.
package mem_bus_arbiter_pkg;

  localparam logic [1:0] MBA_IDLE = 2'd0;
  localparam logic [1:0] MBA_DATA = 2'd1;
  localparam logic [1:0] MBA_INST = 2'd2;
  localparam logic [1:0] MBA_DONE = 2'd3;

  localparam logic [31:0] MBA_ERR_DATA = 32'h0;

  typedef enum logic [1:0] {
    S_IDLE = MBA_IDLE,
    S_DATA = MBA_DATA,
    S_INST = MBA_INST,
    S_DONE = MBA_DONE
  } mba_state_e;

endpackage

// File: rtl/mba_timeout_cnt.sv
// Bus access watchdog: counts unacknowledged bus cycles.
// o_expire flags the last cycle an access may wait.
module mba_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  // Count waiting cycles; clear between accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = (r_cnt == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises core data and fetch accesses onto one bus.
// Data goes first; stall is held until both complete.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA =
    DATA_WIDTH'(MBA_ERR_DATA)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inst_ren,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [DATA_WIDTH-1:0] inst_data,
  input  logic                  mem_ren,
  input  logic                  mem_wen,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  stall,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  bus_err
);

  mba_state_e r_state;
  mba_state_e w_next;

  logic                  r_ipend;
  logic [ADDR_WIDTH-1:0] r_iaddr;

  logic                  w_dreq;
  logic                  w_busy;
  logic                  w_exp;
  logic                  w_done;
  logic                  w_abort;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_dreq  = mem_ren | mem_wen;
  assign w_busy  = (r_state == S_DATA) ||
                   (r_state == S_INST);
  assign w_done  = w_busy & (bus_ack | w_exp);
  assign w_abort = w_busy & w_exp & ~bus_ack;
  assign w_rdata = bus_ack ? bus_rdata : ERR_DATA;

  assign bus_req = w_busy;
  assign stall   = (inst_ren | w_dreq) &
                   (r_state != S_DONE);

  mba_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (~w_busy | w_done),
    .i_en    (w_busy & ~bus_ack),
    .o_expire(w_exp)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state: data before fetch, one DONE cycle.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_dreq)        w_next = S_DATA;
        else if (inst_ren) w_next = S_INST;
      end
      S_DATA: begin
        if (w_done) w_next = r_ipend ? S_INST : S_DONE;
      end
      S_INST: begin
        if (w_done) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Latch the fetch request while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ipend <= 1'b0;
      r_iaddr <= '0;
    end else if (r_state == S_IDLE) begin
      r_ipend <= inst_ren;
      r_iaddr <= inst_addr;
    end
  end

  // Bus command registers, stable through each access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_dreq) begin
        bus_we    <= mem_wen;
        bus_addr  <= mem_addr;
        bus_wdata <= mem_dout;
      end else if (inst_ren) begin
        bus_we    <= 1'b0;
        bus_addr  <= inst_addr;
      end
    end else if (r_state == S_DATA &&
                 w_done && r_ipend) begin
      bus_we   <= 1'b0;
      bus_addr <= r_iaddr;
    end
  end

  // Capture read data on completion; flag aborts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_din   <= '0;
      inst_data <= '0;
      bus_err   <= 1'b0;
    end else begin
      if (r_state == S_DATA && w_done && !bus_we)
        mem_din <= w_rdata;
      if (r_state == S_INST && w_done)
        inst_data <= w_rdata;
      if (w_abort)
        bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomised bench for mem_bus_arbiter.
// A transaction-level model expands each step into cycles.
module tb_mem_bus_arbiter;

  localparam int          TO   = 4;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_ren;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  mem_bus_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT   (TO),
    .ERR_DATA  (ERRD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inst_ren (inst_ren),
    .inst_addr(inst_addr),
    .inst_data(inst_data),
    .mem_ren  (mem_ren),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .mem_dout (mem_dout),
    .mem_din  (mem_din),
    .stall    (stall),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_ack  (bus_ack),
    .bus_rdata(bus_rdata),
    .bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ir, mr, mw;
    logic [31:0] ia, ma, md;
    logic        ack;
    logic [31:0] rdata;
    logic        stall, req, we;
    logic [31:0] addr, wdata;
    logic [31:0] inst, din;
    logic        err;
  } cyc_t;

  cyc_t        plan[$];
  cyc_t        cur;
  bit          cur_vld = 1'b0;
  int          n_chk = 0;
  int          n_err = 0;
  int          stall_hi = 0;
  int          req_hi = 0;

  logic [31:0] m_inst, m_din;
  logic        m_err;
  logic        s_ir, s_mr, s_mw;
  logic [31:0] s_ia, s_ma, s_md;

  function automatic void chk(string nm,
                              logic [31:0] act,
                              logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endfunction

  // Per-cycle comparison against the expanded model.
  always @(negedge clk) begin
    if (cur_vld) begin
      chk("stall", 32'(stall), 32'(cur.stall));
      chk("bus_req", 32'(bus_req), 32'(cur.req));
      if (cur.req) begin
        chk("bus_addr", bus_addr, cur.addr);
        chk("bus_we", 32'(bus_we), 32'(cur.we));
        if (cur.we) chk("bus_wdata", bus_wdata, cur.wdata);
      end
      chk("inst_data", inst_data, cur.inst);
      chk("mem_din", mem_din, cur.din);
      chk("bus_err", 32'(bus_err), 32'(cur.err));
      if (stall === 1'b1) stall_hi++;
      if (bus_req === 1'b1) req_hi++;
    end
  end

  task automatic push(logic st, logic rq, logic we,
                      logic [31:0] a, logic [31:0] wd,
                      logic ak, logic [31:0] rd);
    cyc_t r;
    r.ir = s_ir; r.mr = s_mr; r.mw = s_mw;
    r.ia = s_ia; r.ma = s_ma; r.md = s_md;
    r.ack = ak; r.rdata = rd;
    r.stall = st; r.req = rq; r.we = we;
    r.addr = a; r.wdata = wd;
    r.inst = m_inst; r.din = m_din; r.err = m_err;
    plan.push_back(r);
  endtask

  // One bus access: ack after d waiting cycles, or abort.
  task automatic access(logic [31:0] a, logic we,
                        logic [31:0] wd, int d,
                        logic [31:0] rd, bit is_data);
    int  n;
    bit  ab;
    n  = (d < TO) ? d + 1 : TO;
    ab = (d >= TO);
    for (int k = 0; k < n; k++)
      push(1'b1, 1'b1, we, a, wd, 1'(k == d),
           (k == d) ? rd : $urandom);
    if (ab) m_err = 1'b1;
    if (is_data) begin
      if (!we) m_din = ab ? ERRD : rd;
    end else begin
      m_inst = ab ? ERRD : rd;
    end
  endtask

  task automatic build_step(logic ir, logic [31:0] ia,
                            logic mr, logic mw,
                            logic [31:0] ma, logic [31:0] md,
                            int dd, logic [31:0] rdd,
                            int di, logic [31:0] rdi);
    s_ir = ir; s_mr = mr; s_mw = mw;
    s_ia = ia; s_ma = ma; s_md = md;
    if (!(ir | mr | mw)) begin
      push(1'b0, 1'b0, 1'b0, 0, 0,
           1'($urandom_range(0, 1)), $urandom);
      return;
    end
    push(1'b1, 1'b0, 1'b0, 0, 0,
         1'($urandom_range(0, 1)), $urandom);
    if (mr | mw) access(ma, mw, md, dd, rdd, 1'b1);
    if (ir)      access(ia, 1'b0, 0, di, rdi, 1'b0);
    push(1'b0, 1'b0, 1'b0, 0, 0,
         1'($urandom_range(0, 1)), $urandom);
  endtask

  task automatic apply(cyc_t r);
    inst_ren  = r.ir;
    inst_addr = r.ia;
    mem_ren   = r.mr;
    mem_wen   = r.mw;
    mem_addr  = r.ma;
    mem_dout  = r.md;
    bus_ack   = r.ack;
    bus_rdata = r.rdata;
    cur       = r;
    cur_vld   = 1'b1;
  endtask

  task automatic play(int lim);
    int k = 0;
    while (plan.size() > 0 && k < lim) begin
      @(posedge clk); #1;
      apply(plan.pop_front());
      k++;
    end
    @(negedge clk); #1;
  endtask

  task automatic rand_steps(int n);
    for (int i = 0; i < n; i++) begin
      build_step(1'($urandom_range(0, 1)), $urandom,
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) == 0),
                 $urandom, $urandom,
                 $urandom_range(0, 5), $urandom,
                 $urandom_range(0, 5), $urandom);
      play(1000);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    inst_ren = 0; inst_addr = 0; mem_ren = 0;
    mem_wen = 0; mem_addr = 0; mem_dout = 0;
    bus_ack = 0; bus_rdata = 0;
    m_inst = 0; m_din = 0; m_err = 0;
    #12;
    chk("rst_bus_req", 32'(bus_req), 0);
    chk("rst_bus_we", 32'(bus_we), 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_inst_data", inst_data, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    chk("rst_stall", 32'(stall), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fetch only, immediate ack.
    stall_hi = 0; req_hi = 0;
    build_step(1, 32'h100, 0, 0, 0, 0, 0, 0,
               0, 32'h2008_0005);
    play(100);
    chk("fetch_inst", inst_data, 32'h2008_0005);
    chk("fetch_stall_cyc", stall_hi, 2);
    chk("fetch_req_cyc", req_hi, 1);

    // Load plus fetch, two wait cycles each.
    stall_hi = 0; req_hi = 0;
    build_step(1, 32'h104, 1, 0, 32'h40, 0,
               2, 32'hAAAA_5555, 2, 32'h8C08_0000);
    play(100);
    chk("lf_din", mem_din, 32'hAAAA_5555);
    chk("lf_inst", inst_data, 32'h8C08_0000);
    chk("lf_stall_cyc", stall_hi, 7);
    chk("lf_req_cyc", req_hi, 6);

    // Store leaves mem_din alone.
    stall_hi = 0;
    build_step(0, 0, 0, 1, 32'h80, 32'h1234_5678,
               0, 32'h5A5A_5A5A, 0, 0);
    play(100);
    chk("st_din", mem_din, 32'hAAAA_5555);
    chk("st_stall_cyc", stall_hi, 2);

    // Idle cycles with stray acks.
    for (int i = 0; i < 4; i++)
      build_step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    play(100);
    chk("idle_inst", inst_data, 32'h8C08_0000);

    // Fetch timeout.
    stall_hi = 0; req_hi = 0;
    build_step(1, 32'h200, 0, 0, 0, 0, 0, 0,
               100, 0);
    play(100);
    chk("to_inst", inst_data, ERRD);
    chk("to_err", 32'(bus_err), 1);
    chk("to_req_cyc", req_hi, 4);
    chk("to_stall_cyc", stall_hi, 5);

    build_step(1, 32'h204, 0, 0, 0, 0, 0, 0,
               1, 32'h0123_4567);
    play(100);
    chk("post_to_inst", inst_data, 32'h0123_4567);
    chk("post_to_err", 32'(bus_err), 1);

    rand_steps(150);

    // Asynchronous reset in the middle of a load.
    build_step(0, 0, 1, 0, 32'h300, 0, 10, 0, 0, 0);
    play(3);
    chk("pre_rst_req", 32'(bus_req), 1);
    cur_vld = 1'b0;
    plan.delete();
    rst_n = 1'b0;
    #1;
    chk("arst_bus_req", 32'(bus_req), 0);
    chk("arst_bus_addr", bus_addr, 0);
    chk("arst_mem_din", mem_din, 0);
    chk("arst_inst_data", inst_data, 0);
    chk("arst_bus_err", 32'(bus_err), 0);
    mem_ren = 0; bus_ack = 0;
    inst_ren = 1; inst_addr = 32'h400;
    m_inst = 0; m_din = 0; m_err = 0;
    @(posedge clk); #1;
    chk("arst_hold_req", 32'(bus_req), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    build_step(1, 32'h400, 0, 0, 0, 0, 0, 0,
               0, 32'hCAFE_F00D);
    apply(plan.pop_front());
    play(100);
    chk("rst_fetch_inst", inst_data, 32'hCAFE_F00D);

    rand_steps(100);

    cur_vld = 1'b0;
    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-ported, variable-latency memory bus between the core's instruction-fetch port and its data port.
- Sits between mips_core (inst_* and mem_* ports) and the unified memory.
- Serialises the two accesses per pipeline step and returns a single stall to the core's controller until both are complete.
- Data access is served before instruction fetch, because the MEM-stage instruction is older.

Parameters:
- ADDR_WIDTH, 32, address width of the core and bus.
- DATA_WIDTH, 32, data word width.
- TIMEOUT, 255, max cycles to wait for bus_ack before aborting an access (must be ≥1).
- ERR_DATA, 32'h0, read data returned on an aborted access.

Ports:
- clk  in  1  main clock.
- rst_n  in  1  asynchronous, active-low reset.
- inst_ren  in  1  instruction read request from core.
- inst_addr  in  ADDR_WIDTH  instruction address.
- inst_data  out  DATA_WIDTH  fetched instruction (registered).
- mem_ren  in  1  data read request.
- mem_wen  in  1  data write request.
- mem_addr  in  ADDR_WIDTH  data address.
- mem_dout  in  DATA_WIDTH  write data from core.
- mem_din  out  DATA_WIDTH  read data to core (registered).
- stall  out  1  core must freeze all stages while high.
- bus_req  out  1  bus transaction request.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_WIDTH  bus address.
- bus_wdata  out  DATA_WIDTH  bus write data.
- bus_ack  in  1  transaction complete; bus_rdata valid this cycle.
- bus_rdata  in  DATA_WIDTH  bus read data.
- bus_err  out  1  sticky timeout flag, cleared only by reset.

Behaviour:
- **Reset values** (asynchronous on rst_n=0):
  - state=IDLE.
  - bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0.
  - inst_data=0, mem_din=0, bus_err=0, timeout counter=0.
  - Pending flags cleared.
  - Reset mid-transaction drops bus_req in the same cycle; no completion is reported.
- **States:** IDLE, DATA, INST, DONE.
- **Pending flags:**
  - Sampled in IDLE: dpend = mem_ren|mem_wen; ipend = inst_ren.
  - mem_addr, mem_dout, mem_wen and inst_addr are latched at the same time.
  - mem_ren and mem_wen both high is treated as a write.
- **stall** (combinational) = (inst_ren|mem_ren|mem_wen) & (state != DONE).
  - No requests gives stall=0 in any state.
- **Transitions:**
  - IDLE: dpend → DATA; else ipend → INST; else stay in IDLE.
  - DATA: on completion, ipend → INST, else → DONE.
  - INST: on completion → DONE.
  - DONE: lasts exactly one cycle, with stall=0; the core advances on this edge. Then → IDLE.
- **Bus handshake:**
  - In DATA/INST, bus_req=1 with bus_addr, bus_we and bus_wdata held stable until completion.
  - Completion is bus_req & bus_ack. bus_ack in the first cycle of the state is legal.
  - bus_ack outside DATA/INST is ignored.
  - bus_we=0 in INST.
  - bus_req drops in the cycle after completion.
- **Read capture:**
  - On a read completion, bus_rdata is registered into mem_din (DATA) or inst_data (INST).
  - A write completion leaves mem_din unchanged.
  - Outputs hold until the next completion.
- **Timeout:**
  - The counter clears on entry to DATA/INST and increments each cycle without ack.
  - When it reaches TIMEOUT, the access is aborted: treated as completion with read data ERR_DATA, and bus_err is set.
  - An aborted write is not retried.
- **Latency:**
  - One access with ack in its first bus cycle: stall high 2 cycles (IDLE, DATA/INST), low in DONE.
  - Both accesses with immediate acks: stall high 3 cycles.
- **Request changes:**
  - A request that appears while not in IDLE is not served until the next IDLE.
  - The core holds its requests stable while stalled.

Decomposition:
- Shared header (define.vh style) holds:
  - State encoding constants MBA_IDLE/DATA/INST/DONE (2 bits).
  - Default ERR_DATA value.
- Optional sub-module mba_timeout_cnt: loadable counter with clear, enable and expire output.
- Everything else lives in one module; no further hierarchy.

Test Plan:
- **Fetch only:** inst_ren=1, inst_addr=0x100, ack on first bus cycle with rdata=0x2008_0005 → bus_req 1 cycle with addr 0x100, we=0; stall 1,1,0; inst_data=0x20080005 in DONE.
- **Load plus fetch:**
  - Stimulus: mem_ren @0x40 and inst_ren @0x104; ack delayed 2 cycles each; rdata 0xAAAA_5555 then 0x8C08_0000.
  - Response: DATA transaction first, then INST; stall high 7 cycles then low 1; mem_din=0xAAAA5555, inst_data=0x8C080000.
- **Store:** mem_wen=1, addr 0x80, dout 0x1234_5678, immediate ack → bus_we=1, bus_wdata=0x12345678; mem_din unchanged; stall 1,1,0.
- **Timeout:** TIMEOUT=4, inst_ren with no ack → abort after 4 bus cycles; inst_data=ERR_DATA; bus_err=1 stays set; next fetch with ack proceeds normally.
- **Async reset mid-access:** rst_n=0 while in DATA with bus_req=1 → bus_req, stall-source state and outputs zero immediately, without a clock edge. After release, a pending fetch restarts from IDLE.
- **Idle/stray ack:** no requests with bus_ack pulsed → stall=0, bus_req=0, state stays IDLE, no output change.
